if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit.sv | 93 +++++++++
 tb/tb_if_fetch_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: a sequential PC, an instruction-memory request port and a
// small {pc, inst} buffer feeding decode. A branch redirect flushes the buffer.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_addr_i,
   output logic        ce,
   output logic [31:0] addr,
   input  logic [31:0] inst,
   output logic        id_valid_o,
   input  logic        id_ready_i,
   output logic [31:0] id_pc_o,
   output logic [31:0] id_inst_o
);

   localparam int              PW      = $clog2(DEPTH);
   localparam int              CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

   logic [31:0]   pc_q;
   logic          ce_en_q;
   logic [CW-1:0] count_q;
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];

   logic fetch_fire;
   logic pop;
   logic id_valid;
   logic unused_target_bits;

   // Redirect targets are word-aligned, so the low target bits are dropped.
   assign unused_target_bits = ^branch_target_addr_i[1:0];

   assign ce         = ce_en_q && (count_q < DEPTH_C);
   assign addr       = pc_q;
   assign fetch_fire = ce && !stall_i && !branch_flag_i;
   assign id_valid   = (count_q != '0);
   assign pop        = id_valid && id_ready_i && !branch_flag_i;

   assign id_valid_o = id_valid;
   assign id_pc_o    = id_valid ? pc_mem[rd_ptr_q]   : 32'h0;
   assign id_inst_o  = id_valid ? inst_mem[rd_ptr_q] : 32'h0;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values, independent of the order the blocks are evaluated in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q     <= {RESET_PC[31:2], 2'b00};
         ce_en_q  <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         ce_en_q <= 1'b1;
         if (branch_flag_i) begin
            pc_q     <= {branch_target_addr_i[31:2], 2'b00};
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (fetch_fire) begin
               pc_q     <= pc_q + 32'd4;
               wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (fetch_fire && !pop) begin
               count_q <= count_q + CW'(1);
            end else if (!fetch_fire && pop) begin
               count_q <= count_q - CW'(1);
            end
         end
      end
   end

   // NOTE: the buffer storage carries no reset; stale contents are never visible because
   // the head outputs are masked whenever count is zero.
   always_ff @(posedge clk) begin
      if (fetch_fire) begin
         pc_mem[wr_ptr_q]   <= pc_q;
         inst_mem[wr_ptr_q] <= inst;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with literal expectations, then random
// stall/branch/ready/reset traffic checked every cycle against a queue-based model.
module tb_if_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall_i = 1'b0;
   logic        branch_flag_i = 1'b0;
   logic [31:0] branch_target_addr_i = 32'h0;
   logic        ce;
   logic [31:0] addr;
   logic [31:0] inst;
   logic        id_valid_o;
   logic        id_ready_i = 1'b1;
   logic [31:0] id_pc_o;
   logic [31:0] id_inst_o;

   int n_cmp = 0;
   int n_err = 0;

   if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
      .branch_target_addr_i(branch_target_addr_i), .ce(ce), .addr(addr), .inst(inst),
      .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o),
      .id_inst_o(id_inst_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   assign inst = rom_word(addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Behavioural model: a queue of fetched {pc, inst} pairs plus the next PC.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        q[$];
   logic [31:0] m_pc = RESET_PC;
   bit          m_ce_en = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         q.delete();
         m_pc    = RESET_PC;
         m_ce_en = 1'b0;
      end else begin
         bit can_fetch, do_pop;
         can_fetch = m_ce_en && (q.size() < DEPTH) && !stall_i && !branch_flag_i;
         do_pop    = (q.size() != 0) && id_ready_i && !branch_flag_i;
         if (branch_flag_i) begin
            q.delete();
            m_pc = branch_target_addr_i & 32'hFFFF_FFFC;
         end else begin
            if (do_pop) void'(q.pop_front());
            if (can_fetch) begin
               q.push_back('{pc: m_pc, ins: rom_word(m_pc)});
               m_pc = m_pc + 32'd4;
            end
         end
         m_ce_en = 1'b1;
      end
   end

   always @(negedge clk) begin
      check("ce", {31'h0, ce}, {31'h0, m_ce_en && (q.size() < DEPTH)});
      check("addr", addr, m_pc);
      check("valid", {31'h0, id_valid_o}, {31'h0, q.size() != 0});
      check("id_pc", id_pc_o, (q.size() != 0) ? q[0].pc : 32'h0);
      check("id_inst", id_inst_o, (q.size() != 0) ? q[0].ins : 32'h0);
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit s, input bit b, input logic [31:0] t, input bit r);
      stall_i              = s;
      branch_flag_i        = b;
      branch_target_addr_i = t;
      id_ready_i           = r;
   endtask

   task automatic head_is(input string name, input logic [31:0] pc);
      check({name, "_valid"}, {31'h0, id_valid_o}, 32'h1);
      check({name, "_pc"}, id_pc_o, pc);
      check({name, "_inst"}, id_inst_o, 32'hC0DE_0000 ^ pc);
   endtask

   initial begin
      // Streaming from reset with decode always ready.
      drive(0, 0, 32'h0, 1);
      next(); next();
      check("rst_ce", {31'h0, ce}, 32'h0);
      check("rst_valid", {31'h0, id_valid_o}, 32'h0);
      check("rst_pc", id_pc_o, 32'h0);
      rst = 1'b1;
      check("c0_ce", {31'h0, ce}, 32'h0);
      check("c0_addr", addr, 32'h0);
      next();
      check("c1_ce", {31'h0, ce}, 32'h1);
      check("c1_addr", addr, 32'h0);
      check("c1_valid", {31'h0, id_valid_o}, 32'h0);
      for (int i = 1; i <= 4; i++) begin
         next();
         check("seq_addr", addr, 32'(4 * i));
         head_is("seq", 32'(4 * (i - 1)));
      end

      // Stall for three cycles at pc 0x10: buffer drains, pc holds.
      drive(1, 0, 32'h0, 1);
      for (int i = 0; i < 3; i++) begin
         next();
         check("stall_addr", addr, 32'h10);
         check("stall_valid", {31'h0, id_valid_o}, 32'h0);
      end
      drive(0, 0, 32'h0, 1);
      next();
      head_is("unstall", 32'h10);
      check("unstall_addr", addr, 32'h14);

      // Back-pressure from reset fills the buffer, then drains in order.
      rst = 1'b0;
      drive(0, 0, 32'h0, 0);
      next();
      rst = 1'b1;
      next(); next(); next();
      check("full_ce", {31'h0, ce}, 32'h0);
      check("full_addr", addr, 32'h8);
      head_is("full", 32'h0);
      next();
      check("full_hold_addr", addr, 32'h8);
      head_is("full_hold", 32'h0);
      id_ready_i = 1'b1;
      next();
      head_is("drain1", 32'h4);
      check("drain1_ce", {31'h0, ce}, 32'h1);
      next();
      head_is("drain2", 32'h8);
      check("drain2_addr", addr, 32'hC);
      id_ready_i = 1'b0;
      next();
      check("refill_ce", {31'h0, ce}, 32'h0);

      // Redirect with a full buffer; low target bits are cleared.
      drive(0, 1, 32'h0000_0103, 0);
      next();
      drive(0, 0, 32'h0, 0);
      check("br_valid", {31'h0, id_valid_o}, 32'h0);
      check("br_addr", addr, 32'h100);
      next();
      head_is("br", 32'h100);
      next();
      check("br_full_ce", {31'h0, ce}, 32'h0);

      // Asynchronous reset mid-cycle with two buffered entries.
      #2;
      rst = 1'b0;
      #1;
      check("async_ce", {31'h0, ce}, 32'h0);
      check("async_valid", {31'h0, id_valid_o}, 32'h0);
      check("async_addr", addr, RESET_PC);
      check("async_pc", id_pc_o, 32'h0);
      next();
      rst = 1'b1;
      id_ready_i = 1'b1;
      next();
      check("restart_addr", addr, RESET_PC);
      next();
      head_is("restart", RESET_PC);

      // Redirect to the top of the address space: pc wraps to zero.
      drive(0, 1, 32'hFFFF_FFFC, 1);
      next();
      drive(0, 0, 32'h0, 1);
      check("wrap_addr0", addr, 32'hFFFF_FFFC);
      next();
      head_is("wrap0", 32'hFFFF_FFFC);
      check("wrap_addr1", addr, 32'h0);
      next();
      head_is("wrap1", 32'h0);

      // Randomized traffic, including branch-with-stall and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom % 4) == 0, ($urandom % 12) == 0, $urandom, ($urandom % 3) != 0);
         rst = (($urandom % 400) == 0) ? 1'b0 : 1'b1;
         next();
      end
      rst = 1'b1;
      drive(0, 0, 32'h0, 1);
      next(); next();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
